// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSP48A1 slice through a signed length-N multiply-accumulate.
// Optional build macro MAC_OVF_FLAG_EN adds a sticky signed-overflow output res_ovf.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 2,
  parameter int OPM_LAT = 1,
  parameter int P_LAT   = 1
) (
  input  logic             clk,
  input  logic             RSTOPMODE,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_sub,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ceopmode,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
`ifdef MAC_OVF_FLAG_EN
  output logic             res_ovf,
`endif
  output logic             busy
);
  // All three streams (cmd, op, res) transfer on a rising clk edge where valid and ready are both
  // high; ready never depends combinationally on valid, and an offered res is held until taken.
  localparam int D     = 1 + MUL_LAT + P_LAT;
  localparam int S_CEM = MUL_LAT;
  localparam int S_OPM = 1 + MUL_LAT - OPM_LAT;
  localparam int S_CEP = 1 + MUL_LAT;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
`ifdef MAC_OVF_FLAG_EN
    logic neg;
`endif
  } tag_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             sub_q, sub_d;
  logic             first_q, first_d;
  logic             rstp_q, rstp_d;
  logic [17:0]      a_q, a_d, b_q, b_d;
  logic [47:0]      res_data_q, res_data_d;
  tag_t [D:1]       tag_q, tag_d;
  tag_t             new_tag;
  logic             unused_tag;

  always_ff @(posedge clk or posedge RSTOPMODE) begin
    if (RSTOPMODE) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sub_q      <= 1'b0;
      first_q    <= 1'b0;
      rstp_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sub_q      <= sub_d;
      first_q    <= first_d;
      rstp_q     <= rstp_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sub_d      = sub_q;
    first_d    = first_q;
    rstp_d     = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    new_tag    = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sub_d = cmd_sub;
          rem_d = cmd_len;
          if (cmd_len == '0) begin
            res_data_d = '0;
            state_d    = DONE;
          end else begin
            first_d = 1'b1;
            rstp_d  = 1'b1;
            state_d = FEED;
          end
        end
      end
      FEED: begin
        if (op_valid) begin
          a_d           = op_a;
          b_d           = op_b;
          first_d       = 1'b0;
          rem_d         = rem_q - LEN_W'(1);
          new_tag.v     = 1'b1;
          new_tag.first = first_q;
          new_tag.last  = (rem_q == LEN_W'(1));
`ifdef MAC_OVF_FLAG_EN
          // Sign of the value actually added to P: product sign, flipped when subtracting.
          new_tag.neg   = (op_a != '0) && (op_b != '0) && (op_a[17] ^ op_b[17] ^ sub_q);
`endif
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_q[D].v && tag_q[D].last) begin
          res_data_d = dsp_p;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tag_d = {tag_q[D-1:1], new_tag};
  end

  assign unused_tag   = tag_q[D].first;

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign op_ready     = (state_q == FEED);
  assign res_valid    = (state_q == DONE);
  assign res_data     = res_data_q;
  assign dsp_a        = a_q;
  assign dsp_b        = b_q;
  assign dsp_cea      = tag_q[1].v;
  assign dsp_ceb      = tag_q[1].v;
  assign dsp_cem      = tag_q[S_CEM].v;
  assign dsp_ceopmode = tag_q[S_OPM].v;
  assign dsp_opmode   = tag_q[S_OPM].v ?
                        {sub_q, 3'b000, (tag_q[S_OPM].first ? 2'b00 : 2'b10), 2'b01} : 8'h00;
  assign dsp_cep      = tag_q[S_CEP].v;
  assign dsp_rstp     = rstp_q;

`ifdef MAC_OVF_FLAG_EN
  // The check runs one cycle after the P-capturing cycle, when the registered P shows the new sum.
  logic ovf_q, ovf_d, chk_q, chk_d, acc_neg_q, acc_neg_d, add_neg_q, add_neg_d;

  always_comb begin
    ovf_d     = ovf_q;
    chk_d     = tag_q[S_CEP].v;
    acc_neg_d = tag_q[S_CEP].first ? 1'b0 : dsp_p[47];
    add_neg_d = tag_q[S_CEP].neg;
    if (chk_q && (acc_neg_q == add_neg_q) && (dsp_p[47] != acc_neg_q)) ovf_d = 1'b1;
    if ((state_q == IDLE) && cmd_valid) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge RSTOPMODE) begin
    if (RSTOPMODE) begin
      ovf_q     <= 1'b0;
      chk_q     <= 1'b0;
      acc_neg_q <= 1'b0;
      add_neg_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      chk_q     <= chk_d;
      acc_neg_q <= acc_neg_d;
      add_neg_q <= add_neg_d;
    end
  end

  assign res_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed vectors against dsp_mac_sequencer driving a behavioural DSP48A1 slice.
module tb_dsp_mac_sequencer;
  localparam int LEN_W = 8;
  localparam int D     = 4;

  logic             clk = 1'b0;
  logic             RSTOPMODE = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_sub = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [17:0]      op_a = '0;
  logic [17:0]      op_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
  logic [17:0]      dsp_a, dsp_b;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p;
  logic             busy;

  dsp_mac_sequencer dut (
    .clk(clk), .RSTOPMODE(RSTOPMODE),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_sub(cmd_sub),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
    .dsp_opmode(dsp_opmode), .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep),
    .dsp_rstp(dsp_rstp), .dsp_p(dsp_p), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural slice: A1/B1 -> M -> post-adder -> P ----------------
  logic signed [17:0] sa = '0, sb = '0;
  logic signed [35:0] sm = '0;
  logic [7:0]         sopm = '0;
  logic [47:0]        sp = '0;
  logic [47:0]        zsel, msel, p_next;

  always_comb begin
    zsel   = (sopm[3:2] == 2'b10) ? sp : 48'd0;
    msel   = (sopm[1:0] == 2'b01) ? {{12{sm[35]}}, sm} : 48'd0;
    p_next = sopm[7] ? (zsel - msel) : (zsel + msel);
  end

  always @(posedge clk) begin
    if (dsp_cea) sa <= dsp_a;
    if (dsp_ceb) sb <= dsp_b;
    if (dsp_cem) sm <= sa * sb;
    if (RSTOPMODE) sopm <= '0;
    else if (dsp_ceopmode) sopm <= dsp_opmode;
    if (dsp_rstp) sp <= '0;
    else if (dsp_cep) sp <= p_next;
  end

  assign dsp_p = sp;

  // ---------------- strobe monitor ----------------
  int         cep_cnt = 0, cea_cnt = 0, rstp_cnt = 0;
  logic [7:0] opm_log[$];

  always @(negedge clk) begin
    if (dsp_cep) cep_cnt++;
    if (dsp_cea) cea_cnt++;
    if (dsp_rstp) rstp_cnt++;
    if (dsp_ceopmode) opm_log.push_back(dsp_opmode);
  end

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len, input bit sub);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_sub   = sub;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("cmd_accept_timeout", 64'(n), 64'(0));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("op_accept_timeout", 64'(n), 64'(0));
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int n = 0;
    logic [47:0] exp;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      exp = exp_q.pop_front();
      chk({name, "_res_data"}, 64'(res_data), 64'(exp));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({name, "_cmd_ready_after"}, 64'(cmd_ready), 64'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]        len;
    logic              sub;
    logic [3:0]        gap;
    logic [3:0][17:0]  a;
    logic [3:0][17:0]  b;
    logic [47:0]       exp_data;
    logic [7:0]        opm_first;
    logic [7:0]        opm_next;
  } vec_t;

  function automatic vec_t mk(input int len, input bit sub, input int gap,
                              input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input logic [47:0] e, input logic [7:0] o1, input logic [7:0] o2);
    vec_t r;
    r.len = 8'(len); r.sub = sub; r.gap = 4'(gap);
    r.a[0] = 18'(a0); r.b[0] = 18'(b0); r.a[1] = 18'(a1); r.b[1] = 18'(b1);
    r.a[2] = 18'(a2); r.b[2] = 18'(b2); r.a[3] = 18'(a3); r.b[3] = 18'(b3);
    r.exp_data = e; r.opm_first = o1; r.opm_next = o2;
    return r;
  endfunction

  localparam int NV = 6;
  vec_t vec[NV];

  initial begin
    int b_cep, b_cea, b_rstp, b_opm, bad, hi;
    string nm;

    vec[0] = mk(3, 0, 0, 2, 5, 3, 6, 4, 7, 0, 0, 48'd56, 8'h01, 8'h09);
    vec[1] = mk(3, 1, 0, 2, 5, 3, 6, 4, 7, 0, 0, 48'hFFFF_FFFF_FFC8, 8'h81, 8'h89);
    vec[2] = mk(3, 0, 2, 2, 5, 3, 6, 4, 7, 0, 0, 48'd56, 8'h01, 8'h09);
    vec[3] = mk(4, 0, 1, -7, 9, 100, -3, -5, -5, 131071, 131071, 48'd17179606703, 8'h01, 8'h09);
    vec[4] = mk(1, 1, 0, -131072, -131072, 0, 0, 0, 0, 0, 0, 48'hFFFC_0000_0000, 8'h81, 8'h89);
    vec[5] = mk(4, 1, 3, 1, 1, -1, 1, 10, -10, 0, 5, 48'd100, 8'h81, 8'h89);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_strobes", 64'({busy, op_ready, res_valid, dsp_cea, dsp_ceb, dsp_cem,
                           dsp_cep, dsp_ceopmode, dsp_rstp}), 64'(0));
    chk("rst_data", 64'({dsp_opmode, res_data}), 64'(0));
    chk("rst_operands", 64'({dsp_a, dsp_b}), 64'(0));
    RSTOPMODE = 1'b0;
    tick();

    // table-driven commands
    for (int v = 0; v < NV; v++) begin
      nm     = $sformatf("vec%0d", v);
      b_cep  = cep_cnt;
      b_cea  = cea_cnt;
      b_rstp = rstp_cnt;
      b_opm  = opm_log.size();
      exp_q.push_back(vec[v].exp_data);
      send_cmd(int'(vec[v].len), vec[v].sub);
      chk({nm, "_busy"}, 64'(busy), 64'(1));
      for (int i = 0; i < int'(vec[v].len); i++) begin
        if (i > 0) repeat (int'(vec[v].gap)) tick();
        send_beat(vec[v].a[i], vec[v].b[i]);
      end
      wait_result(nm, D);
      chk({nm, "_cep_count"}, 64'(cep_cnt - b_cep), 64'(vec[v].len));
      chk({nm, "_cea_count"}, 64'(cea_cnt - b_cea), 64'(vec[v].len));
      chk({nm, "_rstp_count"}, 64'(rstp_cnt - b_rstp), 64'(1));
      chk({nm, "_opm_count"}, 64'(opm_log.size() - b_opm), 64'(vec[v].len));
      if (opm_log.size() > b_opm)
        chk({nm, "_opm_first"}, 64'(opm_log[b_opm]), 64'(vec[v].opm_first));
      for (int i = b_opm + 1; i < opm_log.size(); i++)
        chk({nm, "_opm_next"}, 64'(opm_log[i]), 64'(vec[v].opm_next));
    end

    // len=0: result the cycle after accept, no slice activity, op_valid ignored
    b_cep  = cep_cnt;
    b_cea  = cea_cnt;
    b_rstp = rstp_cnt;
    exp_q.push_back(48'd0);
    send_cmd(0, 0);
    op_valid = 1'b1;
    chk("len0_op_ready", 64'(op_ready), 64'(0));
    wait_result("len0", 0);
    op_valid = 1'b0;
    tick();
    chk("len0_cea", 64'(cea_cnt - b_cea), 64'(0));
    chk("len0_cep", 64'(cep_cnt - b_cep), 64'(0));
    chk("len0_rstp", 64'(rstp_cnt - b_rstp), 64'(0));

    // res_ready stall with a competing command offered
    exp_q.push_back(48'd30);
    send_cmd(1, 0);
    send_beat(18'd5, 18'd6);
    bad = 0;
    hi  = 0;
    while (!res_valid && hi < 100) begin tick(); hi++; end
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(2);
    for (int i = 0; i < 10; i++) begin
      if (res_data !== 48'd30 || cmd_ready !== 1'b0 || res_valid !== 1'b1) bad++;
      tick();
    end
    chk("stall_stable", 64'(bad), 64'(0));
    wait_result("stall", 0);
    chk("stall_not_taken", 64'(busy), 64'(0));
    cmd_valid = 1'b0;
    tick();

    // asynchronous abort after the 2nd of 4 beats
    send_cmd(4, 0);
    send_beat(18'd1, 18'd2);
    send_beat(18'd3, 18'd4);
    b_cep = cep_cnt;
    RSTOPMODE = 1'b1;
    #1;
    chk("abort_idle", 64'({busy, op_ready, cmd_ready}), 64'(3'b001));
    chk("abort_strobes", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rstp}), 64'(0));
    chk("abort_opmode", 64'(dsp_opmode), 64'(0));
    chk("abort_dsp_a", 64'({dsp_a, dsp_b}), 64'(0));
    tick();
    tick();
    RSTOPMODE = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) hi++;
      tick();
    end
    chk("abort_no_res", 64'(hi), 64'(0));
    chk("abort_no_cep", 64'(cep_cnt - b_cep), 64'(0));

    b_rstp = rstp_cnt;
    exp_q.push_back(48'hFFFF_FFFF_FFF4);
    send_cmd(1, 0);
    send_beat(-18'sd3, 18'sd4);
    wait_result("after_abort", D);
    chk("after_abort_rstp", 64'(rstp_cnt - b_rstp), 64'(1));

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
